// File: rtl/pulse_pacer.sv
// rtl/pulse_pacer.sv - event pacer: counts event strobes and issues them as
// one-cycle pulses spaced at least GAP clka cycles apart.
module pulse_pacer #(
   parameter int CNT_W = 4,
   parameter int GAP   = 8
) (
   input  logic             clka,
   input  logic             rst,
   input  logic             evt_in,
   input  logic             en,
   input  logic             flush,
   input  logic             clr_ovf,
   output logic             pulse_out,
   output logic [CNT_W-1:0] pending,
   output logic             busy,
   output logic             overflow
);

   typedef enum logic {S_IDLE, S_GAP} state_t;

   localparam logic [7:0]       GAP_LOAD = 8'(GAP - 1);
   localparam logic [CNT_W-1:0] PEND_MAX = '1;
   localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

   state_t           state_q;
   logic [7:0]       gap_q;
   logic [CNT_W-1:0] pend_q;
   logic [CNT_W-1:0] pend_d;
   logic             pulse_q;
   logic             ovf_q;
   logic             ovf_d;

   logic gap_done;
   logic issue;
   logic evt_take;

   // Loading GAP-1 and expiring at zero places the next issue slot exactly
   // GAP edges after the previous issue.
   always_comb begin
      gap_done = (state_q == S_GAP) && (gap_q == 8'd0);
      issue    = ((state_q == S_IDLE) || gap_done) && (pend_q != '0)
                 && en && !flush;
      evt_take = evt_in && !flush;
      pend_d   = pend_q;
      ovf_d    = ovf_q;
      if (clr_ovf) begin
         ovf_d = 1'b0;
      end
      if (flush) begin
         pend_d = '0;
      end else if (evt_take && !issue) begin
         if (pend_q == PEND_MAX) begin
            ovf_d = 1'b1;
         end else begin
            pend_d = pend_q + PEND_ONE;
         end
      end else if (issue && !evt_take) begin
         pend_d = pend_q - PEND_ONE;
      end
   end

   always_ff @(posedge clka or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         gap_q   <= 8'd0;
         pend_q  <= '0;
         pulse_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
         pulse_q <= issue;
         case (state_q)
            S_IDLE: begin
               if (issue) begin
                  gap_q   <= GAP_LOAD;
                  state_q <= S_GAP;
               end
            end
            S_GAP: begin
               if (gap_done) begin
                  if (issue) begin
                     gap_q <= GAP_LOAD;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end else begin
                  gap_q <= gap_q - 8'd1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               gap_q   <= 8'd0;
            end
         endcase
      end
   end

   assign pulse_out = pulse_q;
   assign pending   = pend_q;
   assign overflow  = ovf_q;
   assign busy      = (pend_q != '0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_pulse_pacer.sv
// tb/tb_pulse_pacer.sv - directed vector bench for pulse_pacer (CNT_W=4, GAP=8).
module tb_pulse_pacer;

   logic       clka;
   logic       rst;
   logic       evt_in;
   logic       en;
   logic       flush;
   logic       clr_ovf;
   logic       pulse_out;
   logic [3:0] pending;
   logic       busy;
   logic       overflow;

   int passed = 0;
   int total  = 0;

   typedef struct packed {
      logic [7:0] sec;
      logic       evt;
      logic       en;
      logic       flush;
      logic       clr;
      logic       pulse;
      logic [3:0] pend;
      logic       busy;
      logic       ovf;
   } vec_t;

   vec_t  vq[$];
   string sec_name[6];

   pulse_pacer #(.CNT_W(4), .GAP(8)) dut (
      .clka      (clka),
      .rst       (rst),
      .evt_in    (evt_in),
      .en        (en),
      .flush     (flush),
      .clr_ovf   (clr_ovf),
      .pulse_out (pulse_out),
      .pending   (pending),
      .busy      (busy),
      .overflow  (overflow)
   );

   initial clka = 1'b0;
   always #5 clka = ~clka;

   function automatic void add(input logic [7:0] s, input logic e, input logic n,
                               input logic f, input logic c, input logic p,
                               input logic [3:0] pd, input logic b, input logic o);
      vec_t v;
      v.sec = s; v.evt = e; v.en = n; v.flush = f; v.clr = c;
      v.pulse = p; v.pend = pd; v.busy = b; v.ovf = o;
      vq.push_back(v);
   endfunction

   task automatic check(input string name, input int idx,
                        input logic [6:0] act, input logic [6:0] exp);
      total++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("FAIL %s #%0d: got pulse=%0b pending=%0d busy=%0b ovf=%0b, want pulse=%0b pending=%0d busy=%0b ovf=%0b",
                  name, idx, act[6], act[5:2], act[1], act[0],
                  exp[6], exp[5:2], exp[1], exp[0]);
      end
   endtask

   task automatic drive(input logic e, input logic n, input logic f, input logic c);
      evt_in = e; en = n; flush = f; clr_ovf = c;
      @(posedge clka);
      #1;
   endtask

   function automatic logic [6:0] outs();
      return {pulse_out, pending, busy, overflow};
   endfunction

   initial begin
      int p;
      sec_name[0] = "reset";
      sec_name[1] = "single";
      sec_name[2] = "burst";
      sec_name[3] = "simul_flush";
      sec_name[4] = "saturate";
      sec_name[5] = "en_gap";

      // single event: pulse one edge after counting, idle 8 edges after issue
      add(1, 1,1,0,0, 0,4'd1,1,0);
      add(1, 0,1,0,0, 1,4'd0,1,0);
      for (int k = 0; k < 7; k++) add(1, 0,1,0,0, 0,4'd0,1,0);
      add(1, 0,1,0,0, 0,4'd0,0,0);
      add(1, 0,1,0,0, 0,4'd0,0,0);

      // five-event burst: issues at 2,10,18,26,34
      for (int k = 1; k <= 43; k++) begin
         p = (k <= 2) ? 1 : (k <= 4) ? k - 1 : (k <= 9) ? 4 : (k <= 17) ? 3 :
             (k <= 25) ? 2 : (k <= 33) ? 1 : 0;
         add(2, (k <= 5), 1,0,0,
             (k == 2 || k == 10 || k == 18 || k == 26 || k == 34),
             4'(p), (k <= 41), 0);
      end

      // backlog of 3 with an event on every issue edge, then flush at expiry
      for (int k = 1; k <= 3; k++) add(3, 1,0,0,0, 0,4'(k),1,0);
      for (int k = 4; k <= 27; k++)
         add(3, (k == 4 || k == 12 || k == 20), 1,0,0,
             (k == 4 || k == 12 || k == 20), 4'd3, 1, 0);
      add(3, 1,1,1,0, 0,4'd0,0,0);
      add(3, 0,1,0,0, 0,4'd0,0,0);

      // saturation, overflow priority, issue at full, flush mid-gap
      for (int k = 1; k <= 15; k++) add(4, 1,0,0,0, 0,4'(k),1,0);
      add(4, 1,0,0,0, 0,4'd15,1,1);
      add(4, 1,0,0,0, 0,4'd15,1,1);
      add(4, 1,0,0,1, 0,4'd15,1,1);
      add(4, 0,0,0,1, 0,4'd15,1,0);
      add(4, 0,0,0,0, 0,4'd15,1,0);
      add(4, 1,1,0,0, 1,4'd15,1,0);
      add(4, 1,0,0,0, 0,4'd15,1,1);
      add(4, 0,0,0,1, 0,4'd15,1,0);
      add(4, 0,0,1,0, 0,4'd0,1,0);
      for (int k = 0; k < 4; k++) add(4, 0,1,0,0, 0,4'd0,1,0);
      add(4, 0,1,0,0, 0,4'd0,0,0);

      // en low through gap expiry, issue resumes when en returns
      add(5, 1,0,0,0, 0,4'd1,1,0);
      add(5, 1,0,0,0, 0,4'd2,1,0);
      add(5, 0,1,0,0, 1,4'd1,1,0);
      for (int k = 0; k < 9; k++) add(5, 0,0,0,0, 0,4'd1,1,0);
      add(5, 0,1,0,0, 1,4'd0,1,0);
      for (int k = 0; k < 7; k++) add(5, 0,1,0,0, 0,4'd0,1,0);
      add(5, 0,1,0,0, 0,4'd0,0,0);

      rst = 1'b0; evt_in = 1'b0; en = 1'b0; flush = 1'b0; clr_ovf = 1'b0;
      #2;
      check(sec_name[0], 0, outs(), 7'b0);
      @(posedge clka); #1;
      check(sec_name[0], 1, outs(), 7'b0);
      rst = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].evt, vq[i].en, vq[i].flush, vq[i].clr);
         check(sec_name[vq[i].sec], i,
               outs(), {vq[i].pulse, vq[i].pend, vq[i].busy, vq[i].ovf});
      end

      // asynchronous reset while a pulse is high with a backlog and overflow set
      for (int k = 0; k < 16; k++) drive(1, 0, 0, 0);
      check("rst_prep_sat", 0, outs(), {1'b0, 4'd15, 1'b1, 1'b1});
      drive(0, 0, 1, 0);
      check("rst_prep_flush", 0, outs(), {1'b0, 4'd0, 1'b0, 1'b1});
      for (int k = 0; k < 6; k++) drive(1, 0, 0, 0);
      check("rst_prep_six", 0, outs(), {1'b0, 4'd6, 1'b1, 1'b1});
      drive(0, 1, 0, 0);
      check("rst_prep_pulse", 0, outs(), {1'b1, 4'd5, 1'b1, 1'b1});
      #2;
      rst = 1'b0;
      #1;
      check("rst_async", 0, outs(), 7'b0);
      @(posedge clka); #1;
      check("rst_held", 0, outs(), 7'b0);
      rst = 1'b1;
      drive(0, 1, 0, 0);
      check("rst_after_idle", 0, outs(), 7'b0);
      drive(1, 1, 0, 0);
      check("rst_after_evt", 0, outs(), {1'b0, 4'd1, 1'b1, 1'b0});
      drive(0, 1, 0, 0);
      check("rst_after_pulse", 0, outs(), {1'b1, 4'd0, 1'b1, 1'b0});

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
